sseg_dec: RTL



---
 rtl/sseg_dec.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/sseg_dec.sv
// sseg_dec: snoops an active-low multiplexed 7-segment bus and publishes debounced 3-bit point codes per digit.
// Define SSEG_DEC_TIMEOUT_EN to invalidate digits that have not been refreshed for TIMEOUT_CYC cycles.
module sseg_dec #(
   parameter int DIGITS       = 4,
   parameter int SETTLE_CYC   = 4,
   parameter int STABLE_SCANS = 3,
   parameter int TIMEOUT_CYC  = 1000000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DIGITS-1:0]   an,
   input  logic [6:0]          sseg,
   output logic [3*DIGITS-1:0] points,
   output logic [DIGITS-1:0]   valid,
   output logic                upd,
   output logic                err
);

   localparam int         IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [7:0] SETTLE_MAX = 8'(SETTLE_CYC);
   localparam logic [3:0] STABLE_MAX = 4'(STABLE_SCANS);

   if (DIGITS < 1) begin : g_bad_digits
      $error("sseg_dec: DIGITS must be at least 1");
   end
   if (SETTLE_CYC < 1 || SETTLE_CYC > 255) begin : g_bad_settle
      $error("sseg_dec: SETTLE_CYC must be in 1..255");
   end
   if (STABLE_SCANS < 1 || STABLE_SCANS > 15) begin : g_bad_stable
      $error("sseg_dec: STABLE_SCANS must be in 1..15");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("sseg_dec: TIMEOUT_CYC must be at least 1");
   end

   // Point code lookup; bit 3 flags a recognised pattern.
   function automatic logic [3:0] decode(input logic [6:0] seg);
      case (seg)
         7'b1000000: return 4'b1_000;
         7'b1111001: return 4'b1_001;
         7'b0100100: return 4'b1_010;
         7'b0110000: return 4'b1_011;
         7'b0001100: return 4'b1_100;
         7'b0110110: return 4'b1_111;
         default:    return 4'b0_000;
      endcase
   endfunction

   logic [DIGITS-1:0] an_s1, an_s2, an_q;
   logic [6:0]        sseg_s1, sseg_s2, sseg_q;
   logic [7:0]        settle_cnt;
   logic              done;

   logic [2:0]        cand   [DIGITS];
   logic [3:0]        cnt_q  [DIGITS];
   logic [2:0]        pts    [DIGITS];
   logic [DIGITS-1:0] valid_q;

   logic [IW-1:0]     sel;
   logic              legal;
   logic              same;
   logic              fire;
   logic [3:0]        dec;
   logic              dec_known;
   logic [2:0]        dec_code;
   logic [3:0]        cnt_next;
   logic              publish;
   logic              good_sample;
   logic              bad_sample;
   logic              upd_next;

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      sel = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (!an_s2[i]) sel = IW'(i);
      end
   end

   assign legal       = ($countones(~an_s2) == 1);
   assign same        = ({an_s2, sseg_s2} == {an_q, sseg_q});
   assign fire        = legal && same && (settle_cnt == SETTLE_MAX) && !done;
   assign dec         = decode(sseg_s2);
   assign dec_known   = dec[3];
   assign dec_code    = dec[2:0];
   assign good_sample = fire && dec_known;
   assign bad_sample  = fire && !dec_known;

   always_comb begin
      cnt_next = 4'd1;
      if (dec_code == cand[sel]) begin
         cnt_next = (cnt_q[sel] >= STABLE_MAX) ? STABLE_MAX : cnt_q[sel] + 4'd1;
      end
   end

   assign publish = good_sample && (cnt_next == STABLE_MAX) &&
                    ((dec_code != pts[sel]) || !valid_q[sel]);

`ifdef SSEG_DEC_TIMEOUT_EN
   localparam int          TW      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0]     to_cnt [DIGITS];
   logic [DIGITS-1:0] to_fire;

   // A bad sample freezes the counters so a timeout never coincides with err.
   always_comb begin
      to_fire = '0;
      for (int d = 0; d < DIGITS; d++) begin
         to_fire[d] = (to_cnt[d] == TO_LAST) && !bad_sample &&
                      !(good_sample && (sel == IW'(d)));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int d = 0; d < DIGITS; d++) to_cnt[d] <= '0;
      end else begin
         for (int d = 0; d < DIGITS; d++) begin
            if (good_sample && (sel == IW'(d))) begin
               to_cnt[d] <= '0;
            end else if (!bad_sample && (to_cnt[d] != TO_MAX)) begin
               to_cnt[d] <= to_cnt[d] + 1'b1;
            end
         end
      end
   end

   assign upd_next = publish || (|(to_fire & valid_q));
`else
   assign upd_next = publish;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_s1      <= '1;
         an_s2      <= '1;
         an_q       <= '1;
         sseg_s1    <= '1;
         sseg_s2    <= '1;
         sseg_q     <= '1;
         settle_cnt <= '0;
         done       <= 1'b0;
         valid_q    <= '0;
         upd        <= 1'b0;
         err        <= 1'b0;
         // NOTE: these per-digit arrays are small register files, not RAM, so they are cleared on reset.
         for (int d = 0; d < DIGITS; d++) begin
            cand[d]  <= '0;
            cnt_q[d] <= '0;
            pts[d]   <= '0;
         end
      end else begin
         an_s1   <= an;
         an_s2   <= an_s1;
         an_q    <= an_s2;
         sseg_s1 <= sseg;
         sseg_s2 <= sseg_s1;
         sseg_q  <= sseg_s2;

         if (!same) begin
            settle_cnt <= '0;
            done       <= 1'b0;
         end else if (!legal) begin
            settle_cnt <= '0;
         end else begin
            if (settle_cnt != SETTLE_MAX) settle_cnt <= settle_cnt + 8'd1;
            if (fire) done <= 1'b1;
         end

         err <= bad_sample;
         upd <= upd_next;

         if (bad_sample) begin
            cnt_q[sel] <= '0;
         end else if (good_sample) begin
            cand[sel]  <= dec_code;
            cnt_q[sel] <= cnt_next;
            if (publish) begin
               pts[sel]     <= dec_code;
               valid_q[sel] <= 1'b1;
            end
         end

`ifdef SSEG_DEC_TIMEOUT_EN
         for (int d = 0; d < DIGITS; d++) begin
            if (to_fire[d]) begin
               valid_q[d] <= 1'b0;
               cnt_q[d]   <= '0;
            end
         end
`endif
      end
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_points
      assign points[3*g +: 3] = pts[g];
   end

   assign valid = valid_q;

endmodule
